sram_mem_ctrl: RTL

Memory-stage controller that turns the pipeline's 32-bit load/store requests into sequences of 16-bit accesses on the external asynchronous SRAM. It stalls the pipeline through `ready` until the access completes. It sits between the EXE/MEM pipeline register and the write-back mux. Load data from this block is the value the write-back stage drives as the register-file write data.

---
 rtl/sram_mem_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: runs each 32-bit pipeline load/store as two 16-bit async SRAM accesses, stalling via ready.
// Define SRAM_TRACE_EN to print one $display line per completed access.
module sram_mem_ctrl #(
    parameter int unsigned DATA_BASE     = 1024,
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_wr_q, is_wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      read_data_q, read_data_d;
    logic [16:0]      word_c;
    logic             dq_oe_c;
    logic [15:0]      dq_out_c;

    // Offset from the data base in 32-bit words; upper bits wrap silently.
    assign word_c = 17'((addr_q - DATA_BASE) >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
        end
    end

    // Next state: each half runs ACCESS_CYCLES cycles, read data sampled on the last edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        unique case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    is_wr_d = wr_en;
                    addr_d  = address;
                    wdata_d = write_data;
                    cnt_d   = CNT_LOAD;
                    state_d = LO;
                end
            end
            LO: begin
                if (cnt_q == '0) begin
                    if (!is_wr_q) read_data_d[15:0] = SRAM_DQ;
                    cnt_d   = CNT_LOAD;
                    state_d = HI;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HI: begin
                if (cnt_q == '0) begin
                    if (!is_wr_q) read_data_d[31:16] = SRAM_DQ;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM strobes and ready decode from the current state.
    always_comb begin
        ready     = 1'b0;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_CE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        dq_oe_c   = 1'b0;
        dq_out_c  = wdata_q[15:0];
        unique case (state_q)
            IDLE: ready = !(rd_en || wr_en);
            LO, HI: begin
                SRAM_ADDR = {word_c, state_q == HI};
                SRAM_CE_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_WE_N = !is_wr_q;
                SRAM_OE_N = is_wr_q;
                dq_oe_c   = is_wr_q;
                dq_out_c  = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_oe_c ? dq_out_c : 16'bz;
    assign read_data = read_data_q;

`ifdef SRAM_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && state_q == HI && state_d == DONE)
            $display("sram_mem_ctrl: %s addr=0x%08h data=0x%08h",
                     is_wr_q ? "wr" : "rd", addr_q, is_wr_q ? wdata_q : read_data_d);
    end
`endif

endmodule
